// File: rtl/fp_mult_arbiter.sv
// Shared signed fixed-point multiplier with round-robin arbitration among
// NUM_REQ requesters. Two registered stages (operands, result); each product
// is returned tagged with the index of the requester that issued it.
module fp_mult_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int FRACTIONAL_BITS = 24,
  parameter int INTEGER_BITS    = DATA_WIDTH - FRACTIONAL_BITS,
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = $clog2(NUM_REQ)
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_ovf
);

  // S1: operand register
  logic                  v1;
  logic [DATA_WIDTH-1:0] a1, b1;
  logic [ID_W-1:0]       id1;

  // S2: result register
  logic                  v2;
  logic [DATA_WIDTH-1:0] data2;
  logic                  ovf2;
  logic [ID_W-1:0]       id2;

  // Round-robin priority pointer
  logic [ID_W-1:0]       ptr;

  logic                  adv1, adv2;
  logic                  found, grant;
  logic [ID_W-1:0]       gnt_id, ptr_nxt, idx;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;

  logic [2*DATA_WIDTH-1:0]            prod;
  logic [DATA_WIDTH+INTEGER_BITS-1:0] shifted;
  logic [INTEGER_BITS:0]              top;
  logic [DATA_WIDTH-1:0]              mul_data;
  logic                               mul_ovf;
  logic                               unused_frac;

  assign adv2 = !v2 || rsp_ready;
  assign adv1 = !v1 || adv2;

  // Pick the first valid requester at or after ptr (with wrap) and mux its operands
  always_comb begin
    found   = 1'b0;
    gnt_id  = '0;
    ptr_nxt = ptr;
    gnt_oh  = '0;
    idx     = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        gnt_id      = idx;
        gnt_oh[idx] = 1'b1;
        ptr_nxt     = ID_W'((32'(idx) + 1) % NUM_REQ);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    grant     = found && adv1 && Reset_n;
    req_ready = grant ? gnt_oh : '0;
  end

  // Full-width signed product, arithmetic shift by the fraction, wrap to DATA_WIDTH
  always_comb begin
    // Sign-extending to full width makes the unsigned modular product equal the signed one
    prod        = {{DATA_WIDTH{a1[DATA_WIDTH-1]}}, a1} * {{DATA_WIDTH{b1[DATA_WIDTH-1]}}, b1};
    // Dropping the low fraction bits of the product is the floor (arithmetic) shift
    shifted     = prod[2*DATA_WIDTH-1:FRACTIONAL_BITS];
    top         = shifted[DATA_WIDTH+INTEGER_BITS-1:DATA_WIDTH-1];
    mul_data    = shifted[DATA_WIDTH-1:0];
    mul_ovf     = !((&top) || !(|top));
    unused_frac = ^prod[FRACTIONAL_BITS-1:0];
  end

  // Pipeline advance: S2 takes S1 when free or drained, S1 takes the granted pair
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      v1    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      id1   <= '0;
      v2    <= 1'b0;
      data2 <= '0;
      ovf2  <= 1'b0;
      id2   <= '0;
      ptr   <= '0;
    end else begin
      if (adv2) begin
        v2    <= v1;
        data2 <= mul_data;
        ovf2  <= mul_ovf;
        id2   <= id1;
      end
      if (adv1) begin
        v1 <= grant;
        if (grant) begin
          a1  <= sel_a;
          b1  <= sel_b;
          id1 <= gnt_id;
          ptr <= ptr_nxt;
        end
      end
    end
  end

  assign rsp_valid = v2;
  assign rsp_data  = data2;
  assign rsp_id    = id2;
  assign rsp_ovf   = ovf2;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter: a watcher queues the expected result of
// every transfer, a monitor checks each presented response against the queue head.
module tb_fp_mult_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  id;
    logic        o;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [N-1:0]  rv;
  logic [N*DW-1:0] req_a, req_b;
  logic [N-1:0]  req_ready;
  logic          rsp_valid, rsp_ready, rsp_ovf;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_id;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic [31:0] ex_d [N];
  logic        ex_o [N];

  exp_t        q[$];
  logic [63:0] glog;
  int          total = 0;
  int          bad   = 0;

  fp_mult_arbiter #(.DATA_WIDTH(DW), .FRACTIONAL_BITS(24), .NUM_REQ(N)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req_valid(rv), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = op_a[i];
      req_b[i*DW +: DW] = op_b[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic o);
    op_a[i] = a;
    op_b[i] = b;
    ex_d[i] = d;
    ex_o[i] = o;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && q.size() != 0; c++) step();
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  // Watcher: every transfer about to happen at the next edge queues its expected result
  always @(negedge Clk) begin
    if (Reset_n) begin
      chk("gnt_legal", 64'(req_ready & ~rv), 64'd0);
      for (int i = 0; i < N; i++) begin
        if (rv[i] && req_ready[i]) begin
          exp_t e;
          e.d  = ex_d[i];
          e.id = 2'(i);
          e.o  = ex_o[i];
          q.push_back(e);
          glog = (glog << 4) | 64'(i);
        end
      end
    end
  end

  // Monitor: a presented response must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (Reset_n && rsp_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id %0d data %h, want no response", rsp_id, rsp_data);
      end else begin
        chk("rsp_data", 64'(rsp_data), 64'(q[0].d));
        chk("rsp_id",   64'(rsp_id),   64'(q[0].id));
        chk("rsp_ovf",  64'(rsp_ovf),  64'(q[0].o));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  logic [31:0] va [4] = '{32'h02000000, 32'h01A80000, 32'h03000000, 32'hFC240000};
  logic [31:0] vb [4] = '{32'h02800000, 32'h00A00000, 32'hFF200000, 32'hFF200000};
  logic [31:0] vd [4] = '{32'h05000000, 32'h01090000, 32'hFD600000, 32'h03608000};
  logic [31:0] oa [3] = '{32'h40000000, 32'h7F000000, 32'hFFFFFFFF};
  logic [31:0] ob [3] = '{32'h04000000, 32'h01000000, 32'h00800000};
  logic [31:0] od [3] = '{32'h00000000, 32'h7F000000, 32'hFFFFFFFF};
  logic        oo [3] = '{1'b1, 1'b0, 1'b0};
  logic [3:0]  bp_exp [5] = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    Reset_n   = 1'b0;
    rsp_ready = 1'b0;
    rv        = '1;
    glog      = '0;
    for (int i = 0; i < N; i++) set_op(i, '0, '0, '0, 1'b0);
    repeat (2) step();
    settle();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data",  64'(rsp_data),  64'd0);
    chk("reset_rsp_id",    64'(rsp_id),    64'd0);
    chk("reset_rsp_ovf",   64'(rsp_ovf),   64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);

    // Single products from requester 0, back to back
    Reset_n   = 1'b1;
    rsp_ready = 1'b1;
    rv        = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      set_op(0, va[j], vb[j], vd[j], 1'b0);
      settle();
      if (j == 0) chk("first_grant", 64'(req_ready), 64'b0001);
      if (j == 1) chk("latency_not_yet", 64'(rsp_valid), 64'd0);
      if (j == 2) chk("latency_valid", 64'(rsp_valid), 64'd1);
      step();
    end
    rv = '0;
    drain();

    // Overflow wrap, exact max, negative floor
    rv = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      set_op(0, oa[j], ob[j], od[j], oo[j]);
      settle();
      step();
    end
    rv = '0;
    drain();

    // Backpressure with requesters 1 and 2; pointer sits at 1
    glog = '0;
    set_op(1, 32'h01800000, 32'h02000000, 32'h03000000, 1'b0);
    set_op(2, 32'hFE000000, 32'h01400000, 32'hFD800000, 1'b0);
    rsp_ready = 1'b0;
    rv = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("bp_ready", 64'(req_ready), 64'(bp_exp[c]));
      step();
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp_resume", 64'(req_ready), 64'b0010);
    step();
    rv = '0;
    drain();
    chk("bp_order", glog, 64'h121);

    // Reset with both stages full and the response stalled; pointer sits at 2
    glog = '0;
    set_op(3, 32'h00400000, 32'h08000000, 32'h02000000, 1'b0);
    rsp_ready = 1'b0;
    rv = 4'b1010;
    settle();
    chk("rst_pre_g0", 64'(req_ready), 64'b1000);
    step();
    settle();
    chk("rst_pre_g1", 64'(req_ready), 64'b0010);
    step();
    settle();
    chk("rst_pre_full_ready", 64'(req_ready), 64'd0);
    chk("rst_pre_full_valid", 64'(rsp_valid), 64'd1);
    chk("rst_pre_order", glog, 64'h31);
    Reset_n = 1'b0;
    q.delete();
    rv = '1;
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 1) << 24, 32'h01000000, 32'(i + 1) << 24, 1'b0);
    settle();
    chk("rst_req_ready_low", 64'(req_ready), 64'd0);
    step();
    Reset_n   = 1'b1;
    rsp_ready = 1'b1;
    glog      = '0;
    settle();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data",  64'(rsp_data),  64'd0);
    chk("rst_first_gnt", 64'(req_ready), 64'b0001);

    // Round-robin with all requesters valid, one result per cycle
    for (int c = 0; c < 12; c++) begin
      if (c >= 2) chk("rr_rate", 64'(rsp_valid), 64'd1);
      step();
      settle();
    end
    rv = '0;
    chk("rr_order", glog, 64'h012301230123);
    drain();

    // Sparse requester 3 every third cycle, then pointer must have wrapped to 0
    glog = '0;
    set_op(3, 32'hFFFFFFFF, 32'h00800000, 32'hFFFFFFFF, 1'b0);
    for (int r = 0; r < 3; r++) begin
      rv = 4'b1000;
      settle();
      chk("sparse_gnt", 64'(req_ready), 64'b1000);
      step();
      rv = '0;
      step();
      step();
    end
    chk("sparse_order", glog, 64'h333);
    rv = '1;
    settle();
    chk("sparse_wrap", 64'(req_ready), 64'b0001);
    step();
    rv = '0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
